// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared state encoding and timing defaults for the HDMI link sequencer
package hdmi_pkg;

  // Bring-up sequence states; 6 and 7 are never produced and recover to WAIT_LOCK.
  typedef enum logic [2:0] {
    ST_WAIT_LOCK   = 3'd0,
    ST_SETTLE      = 3'd1,
    ST_DIV_RELEASE = 3'd2,
    ST_TX_RELEASE  = 3'd3,
    ST_RUN         = 3'd4,
    ST_FAULT       = 3'd5
  } link_state_e;

  // Phase and blink counter width; every timing parameter must fit in it.
  localparam int unsigned CNT_W = 24;

  // Defaults sized for a 27 MHz reference clock.
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 27000;
  localparam int unsigned DEF_DIV_SETTLE_CYCLES  = 16;
  localparam int unsigned DEF_TX_SETTLE_CYCLES   = 64;
  localparam int unsigned DEF_RETRY_DELAY_CYCLES = 270000;
  localparam int unsigned DEF_BLINK_HALF_CYCLES  = 13500000;

  // Lock-loss counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hff) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input bit
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hdmi_link_sequencer.sv
// rtl/hdmi_link_sequencer.sv - PLL-lock driven bring-up and fault recovery for the HDMI transmit path
module hdmi_link_sequencer
  import hdmi_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned DIV_SETTLE_CYCLES  = DEF_DIV_SETTLE_CYCLES,
  parameter int unsigned TX_SETTLE_CYCLES   = DEF_TX_SETTLE_CYCLES,
  parameter int unsigned RETRY_DELAY_CYCLES = DEF_RETRY_DELAY_CYCLES,
  parameter int unsigned BLINK_HALF_CYCLES  = DEF_BLINK_HALF_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relink,
  output logic       clkdiv_resetn,
  output logic       tx_reset,
  output logic       video_enable,
  output logic       led_n,
  output logic [2:0] state,
  output logic [7:0] lock_loss_count
);

  // Terminal counts: a stage of N cycles ends on the edge where the counter reads N-1.
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(TX_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_DELAY_CYCLES - 1);
  localparam int unsigned BLINK_FAST_CYCLES =
    (BLINK_HALF_CYCLES / 4 == 0) ? 1 : BLINK_HALF_CYCLES / 4;
  localparam logic [CNT_W-1:0] BLINK_SLOW_LAST = CNT_W'(BLINK_HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_FAST_LAST = CNT_W'(BLINK_FAST_CYCLES - 1);

  logic              lock_s;
  link_state_e       state_q;
  link_state_e       next_state;
  logic [CNT_W-1:0]  phase_cnt;
  logic [CNT_W-1:0]  blink_cnt;
  logic [CNT_W-1:0]  blink_last;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign state = state_q;

  // Next-state decision; only the synchronized lock is ever consulted.
  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!lock_s)                     next_state = ST_WAIT_LOCK;
        else if (phase_cnt == LOCK_LAST) next_state = ST_DIV_RELEASE;
      end
      ST_DIV_RELEASE: begin
        if (!lock_s)                    next_state = ST_FAULT;
        else if (phase_cnt == DIV_LAST) next_state = ST_TX_RELEASE;
      end
      ST_TX_RELEASE: begin
        if (!lock_s)                   next_state = ST_FAULT;
        else if (phase_cnt == TX_LAST) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) next_state = ST_FAULT;
      end
      ST_FAULT: begin
        if (relink || phase_cnt == RETRY_LAST) next_state = ST_WAIT_LOCK;
      end
      default: next_state = ST_WAIT_LOCK;
    endcase
  end

  // The blink period shortens while the link sits in FAULT.
  always_comb begin
    blink_last = (next_state == ST_FAULT) ? BLINK_FAST_LAST : BLINK_SLOW_LAST;
  end

  // State, counters and every output are registered from next_state so they change together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_WAIT_LOCK;
      phase_cnt       <= '0;
      blink_cnt       <= '0;
      clkdiv_resetn   <= 1'b0;
      tx_reset        <= 1'b1;
      video_enable    <= 1'b0;
      led_n           <= 1'b1;
      lock_loss_count <= 8'd0;
    end else begin
      state_q <= next_state;

      if (next_state != state_q || state_q == ST_WAIT_LOCK || state_q == ST_RUN) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end

      clkdiv_resetn <= (next_state == ST_DIV_RELEASE) ||
                       (next_state == ST_TX_RELEASE)  ||
                       (next_state == ST_RUN);
      tx_reset      <= !((next_state == ST_TX_RELEASE) || (next_state == ST_RUN));
      video_enable  <= (next_state == ST_RUN);

      if (state_q == ST_RUN && next_state == ST_FAULT) begin
        lock_loss_count <= sat_inc8(lock_loss_count);
      end

      if (next_state == ST_RUN) begin
        led_n     <= 1'b0;
        blink_cnt <= '0;
      end else if (blink_cnt >= blink_last) begin
        led_n     <= ~led_n;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// tb/tb_hdmi_link_sequencer.sv - directed self-checking bench for hdmi_link_sequencer
module tb_hdmi_link_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       relink;
  logic       clkdiv_resetn;
  logic       tx_reset;
  logic       video_enable;
  logic       led_n;
  logic [2:0] state;
  logic [7:0] lock_loss_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_SETL  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_TX    = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  hdmi_link_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .DIV_SETTLE_CYCLES  (4),
    .TX_SETTLE_CYCLES   (4),
    .RETRY_DELAY_CYCLES (16),
    .BLINK_HALF_CYCLES  (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_lock        (pll_lock),
    .relink          (relink),
    .clkdiv_resetn   (clkdiv_resetn),
    .tx_reset        (tx_reset),
    .video_enable    (video_enable),
    .led_n           (led_n),
    .state           (state),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
    int n = 0;
    while (state !== tgt && n < budget) begin
      tick();
      n++;
    end
    check(tag, {29'd0, state}, {29'd0, tgt});
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic cd,
                            input logic tr, input logic ve);
    check({tag, "_state"}, {29'd0, state}, {29'd0, st});
    check({tag, "_clkdiv_resetn"}, {31'd0, clkdiv_resetn}, {31'd0, cd});
    check({tag, "_tx_reset"}, {31'd0, tx_reset}, {31'd0, tr});
    check({tag, "_video_enable"}, {31'd0, video_enable}, {31'd0, ve});
  endtask

  initial begin
    reset    = 1'b1;
    pll_lock = 1'b0;
    relink   = 1'b0;
    tick(3);

    // Reset values
    check_outs("rst", S_WAIT, 1'b0, 1'b1, 1'b0);
    check("rst_led_n", {31'd0, led_n}, 32'd1);
    check("rst_count", {24'd0, lock_loss_count}, 32'd0);

    // Slow blink in WAIT_LOCK: toggle on every 8th edge
    reset = 1'b0;
    tick(7);
    check("blink_wait_7", {31'd0, led_n}, 32'd1);
    tick(1);
    check("blink_wait_8", {31'd0, led_n}, 32'd0);
    tick(7);
    check("blink_wait_15", {31'd0, led_n}, 32'd0);
    tick(1);
    check("blink_wait_16", {31'd0, led_n}, 32'd1);

    // Bring-up with lock high from reset release
    reset = 1'b1;
    pll_lock = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    check("bu_sync_wait", {29'd0, state}, {29'd0, S_WAIT});
    tick(1);
    check_outs("bu_settle", S_SETL, 1'b0, 1'b1, 1'b0);
    tick(7);
    check_outs("bu_settle_last", S_SETL, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_outs("bu_div", S_DIV, 1'b1, 1'b1, 1'b0);
    tick(3);
    check_outs("bu_div_last", S_DIV, 1'b1, 1'b1, 1'b0);
    tick(1);
    check_outs("bu_tx", S_TX, 1'b1, 1'b0, 1'b0);
    tick(3);
    check_outs("bu_tx_last", S_TX, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_outs("bu_run", S_RUN, 1'b1, 1'b0, 1'b1);
    check("bu_run_led", {31'd0, led_n}, 32'd0);
    check("bu_count", {24'd0, lock_loss_count}, 32'd0);

    // relink while in RUN is ignored
    relink = 1'b1;
    tick(1);
    relink = 1'b0;
    tick(2);
    check_outs("relink_run", S_RUN, 1'b1, 1'b0, 1'b1);

    // Lock loss in RUN, fast blink, retry timeout
    pll_lock = 1'b0;
    tick(2);
    check("drop_still_run", {29'd0, state}, {29'd0, S_RUN});
    tick(1);
    check_outs("drop_fault", S_FAULT, 1'b0, 1'b1, 1'b0);
    check("drop_count", {24'd0, lock_loss_count}, 32'd1);
    check("fblink_0", {31'd0, led_n}, 32'd0);
    tick(1);
    check("fblink_1", {31'd0, led_n}, 32'd1);
    tick(1);
    check("fblink_2", {31'd0, led_n}, 32'd1);
    tick(1);
    check("fblink_3", {31'd0, led_n}, 32'd0);
    pll_lock = 1'b1;
    tick(12);
    check("retry_15", {29'd0, state}, {29'd0, S_FAULT});
    tick(1);
    check("retry_16", {29'd0, state}, {29'd0, S_WAIT});
    tick(1);
    check("retry_settle", {29'd0, state}, {29'd0, S_SETL});
    wait_state(S_RUN, 40, "retry_run");

    // relink three cycles into FAULT
    pll_lock = 1'b0;
    wait_state(S_FAULT, 10, "rl_fault");
    check("rl_count", {24'd0, lock_loss_count}, 32'd2);
    tick(2);
    check("rl_fault_2", {29'd0, state}, {29'd0, S_FAULT});
    relink = 1'b1;
    tick(1);
    relink = 1'b0;
    check("rl_wait", {29'd0, state}, {29'd0, S_WAIT});
    tick(1);
    check("rl_wait_hold", {29'd0, state}, {29'd0, S_WAIT});

    // Lock glitch during SETTLE restarts the full settle
    pll_lock = 1'b1;
    tick(3);
    check("gl_settle", {29'd0, state}, {29'd0, S_SETL});
    tick(2);
    pll_lock = 1'b0;
    tick(2);
    check("gl_settle_still", {29'd0, state}, {29'd0, S_SETL});
    tick(1);
    check("gl_wait", {29'd0, state}, {29'd0, S_WAIT});
    pll_lock = 1'b1;
    tick(3);
    check("gl_resettle", {29'd0, state}, {29'd0, S_SETL});
    tick(7);
    check("gl_resettle_last", {29'd0, state}, {29'd0, S_SETL});
    tick(1);
    check("gl_div", {29'd0, state}, {29'd0, S_DIV});
    check("gl_count", {24'd0, lock_loss_count}, 32'd2);

    // Lock loss in DIV_RELEASE faults without counting
    pll_lock = 1'b0;
    wait_state(S_FAULT, 10, "div_fault");
    check("div_fault_count", {24'd0, lock_loss_count}, 32'd2);
    pll_lock = 1'b1;
    relink = 1'b1;
    tick(1);
    relink = 1'b0;
    wait_state(S_RUN, 40, "div_rerun");

    // Saturation after 300 further losses in RUN (2 + 300 -> 255)
    for (int k = 0; k < 300; k++) begin
      pll_lock = 1'b0;
      wait_state(S_FAULT, 10, "sat_fault");
      pll_lock = 1'b1;
      relink = 1'b1;
      tick(1);
      relink = 1'b0;
      wait_state(S_RUN, 40, "sat_run");
    end
    check("sat_count", {24'd0, lock_loss_count}, 32'd255);

    // Asynchronous reset while in TX_RELEASE
    pll_lock = 1'b0;
    wait_state(S_FAULT, 10, "ar_fault");
    pll_lock = 1'b1;
    relink = 1'b1;
    tick(1);
    relink = 1'b0;
    wait_state(S_TX, 40, "ar_tx");
    reset = 1'b1;
    #2;
    check_outs("ar_async", S_WAIT, 1'b0, 1'b1, 1'b0);
    check("ar_led", {31'd0, led_n}, 32'd1);
    check("ar_count", {24'd0, lock_loss_count}, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(2);
    check("ar_restart_wait", {29'd0, state}, {29'd0, S_WAIT});
    tick(1);
    check("ar_restart_settle", {29'd0, state}, {29'd0, S_SETL});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdmi_link_sequencer.md
HDMI_LINK_SEQUENCER -- requirements
Module: hdmi_link_sequencer

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 27000: cycles pll_lock must stay high before bring-up continues (1 ms at 27 MHz).
REQ-002 Parameter DIV_SETTLE_CYCLES, default 16: cycles after clkdiv_resetn rises before tx_reset falls.
REQ-003 Parameter TX_SETTLE_CYCLES, default 64: cycles after tx_reset falls before video_enable rises.
REQ-004 Parameter RETRY_DELAY_CYCLES, default 270000: cycles spent in FAULT before relock attempt.
REQ-005 Parameter BLINK_HALF_CYCLES, default 13500000: LED toggle interval while not in RUN.
REQ-006 clk  input  1  free-running board reference clock; the only clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 pll_lock  input  1  HDMI PLL LOCK, asynchronous to clk.
REQ-009 relink  input  1  single-cycle request to restart the link from FAULT.
REQ-010 clkdiv_resetn  output  1  drives 5:1 clock divider RESETN; low = divider held.
REQ-011 tx_reset  output  1  active-high reset to HDMI encoder/serializer.
REQ-012 video_enable  output  1  high = timing generator and pixel source may run.
REQ-013 led_n  output  1  active-low status LED.
REQ-014 state  output  3  current FSM state encoding.
REQ-015 lock_loss_count  output  8  saturating count of lock losses seen in RUN.

Function
REQ-016 pll_lock SHALL pass a 2-flop synchronizer; lock_s = synchronized value, 2-cycle latency; all FSM decisions use lock_s only.
REQ-017 States SHALL be WAIT_LOCK=0, SETTLE=1, DIV_RELEASE=2, TX_RELEASE=3, RUN=4, FAULT=5; encodings 6-7 unreachable and SHALL go to WAIT_LOCK.
REQ-018 WAIT_LOCK: counter cleared; lock_s=1 -> SETTLE.
REQ-019 SETTLE: counter increments while lock_s=1; lock_s=0 -> WAIT_LOCK (counter cleared); counter reaching LOCK_STABLE_CYCLES-1 with lock_s=1 -> DIV_RELEASE.
REQ-020 DIV_RELEASE: clkdiv_resetn=1; after DIV_SETTLE_CYCLES cycles -> TX_RELEASE.
REQ-021 TX_RELEASE: clkdiv_resetn=1, tx_reset=0; after TX_SETTLE_CYCLES cycles -> RUN.
REQ-022 RUN: clkdiv_resetn=1, tx_reset=0, video_enable=1, led_n=0 constant.
REQ-023 lock_s=0 in DIV_RELEASE, TX_RELEASE or RUN SHALL enter FAULT next cycle; registered outputs return to held values (clkdiv_resetn=0, tx_reset=1, video_enable=0) in that same transition.
REQ-024 Entry to FAULT from RUN SHALL increment lock_loss_count, saturating at 255; entry from other states SHALL not count.
REQ-025 FAULT: counter increments; reaching RETRY_DELAY_CYCLES-1, or relink=1 on any FAULT cycle, -> WAIT_LOCK; relink in other states ignored.
REQ-026 Outputs SHALL be registered; state-to-output latency 0 cycles relative to state register.
REQ-027 Outside RUN, led_n SHALL toggle every BLINK_HALF_CYCLES cycles via independent blink counter; in FAULT toggle interval SHALL be BLINK_HALF_CYCLES/4 (fast blink).
REQ-028 Phase counter SHALL be 24 bits and clear on every state change; all parameters SHALL be in 1..2^24-1.

Reset
REQ-029 On reset: state=WAIT_LOCK, clkdiv_resetn=0, tx_reset=1, video_enable=0, led_n=1, lock_loss_count=0, counters and synchronizer=0.
REQ-030 Reset asserted mid-sequence (any state) SHALL take effect immediately (asynchronous); deassertion restarts from WAIT_LOCK with no retained progress.

Structure
REQ-031 State encoding enum and default timing constants SHALL reside in shared package hdmi_pkg.
REQ-032 Synchronizer SHALL be sub-module sync_2ff (1-bit, reused by other cross-domain inputs).

Verification (params: LOCK_STABLE=8, DIV_SETTLE=4, TX_SETTLE=4, RETRY=16, BLINK_HALF=8)
REQ-033 Lock high steady from reset release -> SETTLE 2 cycles after lock, clkdiv_resetn rises ~10 cycles later, tx_reset falls 4 later, video_enable rises 4 later; count 0.
REQ-034 Lock glitch low 3 cycles during SETTLE -> return to WAIT_LOCK, full 8-cycle settle restarts, no count change.
REQ-035 Lock drop in RUN -> FAULT, all three outputs held next cycle, count=1; relock after 16 cycles in FAULT restarts bring-up.
REQ-036 relink pulse 3 cycles into FAULT -> WAIT_LOCK next cycle; relink pulse in RUN -> no effect.
REQ-037 300 RUN-lock losses -> lock_loss_count stays 255.
REQ-038 Reset asserted in TX_RELEASE -> outputs to reset values without clk edge; led_n toggles every 8 cycles in WAIT_LOCK, every 2 in FAULT.
